complex_div: RTL

Sequential fixed-point complex divider for the sfir datapath: computes q = a / b for signed complex a (A_WIDTH) and b (B_WIDTH) as q = a·conj(b) / |b|², returning a signed Q_WIDTH result with FRAC_BITS fractional bits. It performs the inverse of the team's pipelined complex multiplier and is used for channel/tap normalisation where throughput is low. Inputs and outputs use valid/ready handshakes, and one division is in flight at a time.

---
 rtl/complex_div_pkg.sv | 26 ++
 rtl/udiv_seq.sv | 50 +++++
 rtl/complex_div.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/complex_div_pkg.sv
// ============================================================================
// Module : complex_div_pkg
// Brief  : Shared types and helpers for the sequential complex divider.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package complex_div_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MULT0 = 3'd1,
    MULT1 = 3'd2,
    DIV   = 3'd3,
    FIX   = 3'd4,
    DONE  = 3'd5
  } state_t;

  // One quotient bit per cycle over the full scaled-numerator width.
  function automatic int calc_iter(input int a_w, input int b_w, input int frac);
    return a_w + b_w + 1 + frac;
  endfunction

endpackage

`default_nettype wire

// File: rtl/udiv_seq.sv
// ============================================================================
// Module : udiv_seq
// Brief  : Unsigned restoring divider, one quotient bit per step, MSB first.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module udiv_seq #(
  parameter int DW = 50,
  parameter int VW = 36
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          load_i,
  input  logic          step_i,
  input  logic [DW-1:0] dividend_i,
  input  logic [VW-1:0] divisor_i,
  output logic [DW-1:0] quotient_o
);

  logic [VW-1:0] r_rem;
  logic [DW-1:0] r_dq;
  logic [VW-1:0] r_den;
  logic [VW:0]   w_trial;
  logic          w_ge;

  // Remainder stays below the divisor, so VW bits hold it between steps.
  assign w_trial = {r_rem, r_dq[DW-1]};
  assign w_ge    = (w_trial >= {1'b0, r_den});

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_rem <= '0;
      r_dq  <= '0;
      r_den <= '0;
    end else if (load_i) begin
      r_rem <= '0;
      r_dq  <= dividend_i;
      r_den <= divisor_i;
    end else if (step_i) begin
      r_rem <= w_ge ? VW'(w_trial - {1'b0, r_den}) : w_trial[VW-1:0];
      r_dq  <= {r_dq[DW-2:0], w_ge};
    end
  end

  assign quotient_o = r_dq;

endmodule

`default_nettype wire

// File: rtl/complex_div.sv
// ============================================================================
// Module : complex_div
// Brief  : Sequential fixed-point complex divider q = a*conj(b)/|b|^2.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module complex_div
  import complex_div_pkg::*;
#(
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 18,
  parameter int FRAC_BITS = 15,
  parameter int Q_WIDTH   = 16
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      s_valid_i,
  output logic                      s_ready_o,
  input  logic signed [A_WIDTH-1:0] ar_i,
  input  logic signed [A_WIDTH-1:0] ai_i,
  input  logic signed [B_WIDTH-1:0] br_i,
  input  logic signed [B_WIDTH-1:0] bi_i,
  output logic                      m_valid_o,
  input  logic                      m_ready_i,
  output logic signed [Q_WIDTH-1:0] qr_o,
  output logic signed [Q_WIDTH-1:0] qi_o,
  output logic                      dz_o,
  output logic                      ovf_o
);

  localparam int NW   = A_WIDTH + B_WIDTH + 1;
  localparam int PW   = A_WIDTH + B_WIDTH;
  localparam int VW   = 2 * B_WIDTH;
  localparam int ITER = calc_iter(A_WIDTH, B_WIDTH, FRAC_BITS);
  localparam int DW   = NW + FRAC_BITS;
  localparam int CW   = $clog2(ITER);
  localparam logic [DW-1:0] c_pos_lim = DW'((64'd1 << (Q_WIDTH-1)) - 64'd1);
  localparam logic [DW-1:0] c_neg_lim = DW'(64'd1 << (Q_WIDTH-1));

  state_t r_state, w_next;

  logic signed [A_WIDTH-1:0] r_ar, r_ai;
  logic signed [B_WIDTH-1:0] r_br, r_bi;
  logic signed [PW-1:0]      r_p_arbr, r_p_aibi, r_p_aibr, r_p_arbi;
  logic [VW-1:0]             r_p_brbr, r_p_bibi;
  logic                      r_neg_r, r_neg_i, r_dz;
  logic [CW-1:0]             r_cnt;

  logic signed [NW-1:0] w_nr, w_ni;
  logic [NW-1:0]        w_nr_mag, w_ni_mag;
  logic [VW-1:0]        w_den;
  logic [DW-1:0]        w_quo_r, w_quo_i;
  logic [Q_WIDTH:0]     w_sat_r, w_sat_i;
  logic                 w_load, w_step;

  assign w_nr     = NW'(r_p_arbr) + NW'(r_p_aibi);
  assign w_ni     = NW'(r_p_aibr) - NW'(r_p_arbi);
  assign w_den    = r_p_brbr + r_p_bibi;
  assign w_nr_mag = w_nr[NW-1] ? -w_nr : w_nr;
  assign w_ni_mag = w_ni[NW-1] ? -w_ni : w_ni;

  // Returns {ovf, q}: signed result from sign and magnitude, clamped to Q_WIDTH.
  function automatic logic [Q_WIDTH:0] saturate(input logic neg, input logic [DW-1:0] mag);
    logic [Q_WIDTH-1:0] q;
    logic               ovf;
    ovf = 1'b0;
    q   = mag[Q_WIDTH-1:0];
    if (neg) begin
      if (mag > c_neg_lim) begin
        ovf = 1'b1;
        q   = {1'b1, {(Q_WIDTH-1){1'b0}}};
      end else begin
        q = -mag[Q_WIDTH-1:0];
      end
    end else if (mag > c_pos_lim) begin
      ovf = 1'b1;
      q   = {1'b0, {(Q_WIDTH-1){1'b1}}};
    end
    return {ovf, q};
  endfunction

  assign w_sat_r = saturate(r_neg_r, w_quo_r);
  assign w_sat_i = saturate(r_neg_i, w_quo_i);

  udiv_seq #(.DW(DW), .VW(VW)) u_div_re (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .load_i     (w_load),
    .step_i     (w_step),
    .dividend_i ({w_nr_mag, {FRAC_BITS{1'b0}}}),
    .divisor_i  (w_den),
    .quotient_o (w_quo_r)
  );

  udiv_seq #(.DW(DW), .VW(VW)) u_div_im (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .load_i     (w_load),
    .step_i     (w_step),
    .dividend_i ({w_ni_mag, {FRAC_BITS{1'b0}}}),
    .divisor_i  (w_den),
    .quotient_o (w_quo_i)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (s_valid_i) w_next = MULT0;
      MULT0:   w_next = MULT1;
      MULT1:   w_next = (w_den == '0) ? FIX : DIV;
      DIV:     if (r_cnt == '0) w_next = FIX;
      FIX:     w_next = DONE;
      DONE:    if (m_ready_i) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    s_ready_o = (r_state == IDLE);
    m_valid_o = (r_state == DONE);
    w_load    = (r_state == MULT1);
    w_step    = (r_state == DIV);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_ar     <= '0;
      r_ai     <= '0;
      r_br     <= '0;
      r_bi     <= '0;
      r_p_arbr <= '0;
      r_p_aibi <= '0;
      r_p_aibr <= '0;
      r_p_arbi <= '0;
      r_p_brbr <= '0;
      r_p_bibi <= '0;
      r_neg_r  <= 1'b0;
      r_neg_i  <= 1'b0;
      r_dz     <= 1'b0;
      r_cnt    <= '0;
      qr_o     <= '0;
      qi_o     <= '0;
      dz_o     <= 1'b0;
      ovf_o    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (s_valid_i) begin
          r_ar <= ar_i;
          r_ai <= ai_i;
          r_br <= br_i;
          r_bi <= bi_i;
        end
        MULT0: begin
          r_p_arbr <= PW'(r_ar) * PW'(r_br);
          r_p_aibi <= PW'(r_ai) * PW'(r_bi);
          r_p_aibr <= PW'(r_ai) * PW'(r_br);
          r_p_arbi <= PW'(r_ar) * PW'(r_bi);
          r_p_brbr <= VW'(r_br) * VW'(r_br);
          r_p_bibi <= VW'(r_bi) * VW'(r_bi);
        end
        MULT1: begin
          r_neg_r <= w_nr[NW-1];
          r_neg_i <= w_ni[NW-1];
          r_dz    <= (w_den == '0);
          r_cnt   <= CW'(ITER - 1);
        end
        DIV: r_cnt <= r_cnt - 1'b1;
        FIX: begin
          if (r_dz) begin
            qr_o  <= '0;
            qi_o  <= '0;
            dz_o  <= 1'b1;
            ovf_o <= 1'b0;
          end else begin
            qr_o  <= w_sat_r[Q_WIDTH-1:0];
            qi_o  <= w_sat_i[Q_WIDTH-1:0];
            dz_o  <= 1'b0;
            ovf_o <= w_sat_r[Q_WIDTH] | w_sat_i[Q_WIDTH];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
